// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle for seq_alu.
// master = issuing stage (register file side), slave = seq_alu.
// Both channels use valid/ready. A transfer happens on a rising edge where
// valid && ready. The sender holds its payload stable while valid && !ready.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [7:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cb;
  logic [WIDTH-1:0] ext;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, operand_a, operand_b, opcode, out_ready,
    input  in_ready, out_valid, result, cb, ext, zero, busy
  );

  modport slave (
    input  in_valid, operand_a, operand_b, opcode, out_ready,
    output in_ready, out_valid, result, cb, ext, zero, busy
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with a one-slot output register.
// Single-cycle ops complete on the accept edge. MUL runs a WIDTH-step
// shift-add engine. Optional macro ALU_DIV_EN adds a WIDTH-step restoring
// divider on opcode 0100xxxx. Without the macro that opcode is a NOP.
// dbg_state exposes the FSM state (0 idle, 1 mul, 2 div).
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_alu_if.slave    bus,
  output logic [1:0]  dbg_state
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Engine registers: MUL {hi,lo} = partial product / multiplier, opnd = multiplicand.
  //                   DIV hi = remainder, lo = quotient/dividend, opnd = divisor.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cb_q;
  logic [WIDTH-1:0] ext_q;
  logic             zero_q;

  logic             in_ready_w;
  logic             accept;
  logic             is_mul;
  logic             is_div;

  logic [WIDTH-1:0] sc_result;
  logic             sc_cb;
  logic [WIDTH-1:0] sc_ext;
  logic [WIDTH:0]   sc_sum;
  logic [WIDTH:0]   sc_diff;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  // A drained output slot frees the block on the same edge, so accepts can
  // run back to back while results are consumed every cycle.
  assign in_ready_w    = (state == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready_w;
  assign is_mul        = (bus.opcode[7:4] == 4'b0011);
`ifdef ALU_DIV_EN
  assign is_div        = (bus.opcode[7:4] == 4'b0100);
`else
  assign is_div        = 1'b0;
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cb        = cb_q;
  assign bus.ext       = ext_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state != S_IDLE);
  assign dbg_state     = state;

  // Single-cycle datapath, evaluated on the live operands at the accept edge.
  always_comb begin
    sc_result = bus.operand_a;
    sc_cb     = 1'b0;
    sc_ext    = '0;
    sc_sum    = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    sc_diff   = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
    casez (bus.opcode)
      8'b0001????: begin sc_result = sc_sum[WIDTH-1:0];  sc_cb = sc_sum[WIDTH];  end
      8'b0010????: begin sc_result = sc_diff[WIDTH-1:0]; sc_cb = sc_diff[WIDTH]; end
`ifdef ALU_DIV_EN
      // Only reaches the output for a zero divisor; nonzero goes to the engine.
      8'b0100????: begin sc_result = '1; sc_ext = bus.operand_a; sc_cb = 1'b1; end
`endif
      8'b0101????: sc_result = bus.operand_a & bus.operand_b;
      8'b0110????: sc_result = bus.operand_a ^ bus.operand_b;
      8'b0111????: begin sc_result = '0; sc_cb = sc_diff[WIDTH]; end
      8'b00000001: sc_result = {bus.operand_a[WIDTH-2:0], 1'b0};
      8'b00000010: sc_result = {1'b0, bus.operand_a[WIDTH-1:1]};
      8'b00000011: sc_result = {bus.operand_a[0], bus.operand_a[WIDTH-1:1]};
      8'b00000100: sc_result = {bus.operand_a[WIDTH-2:0], bus.operand_a[WIDTH-1]};
      8'b00000101: sc_result = {bus.operand_a[WIDTH-1], bus.operand_a[WIDTH-1:1]};
      8'b00000110: begin sc_result = sc_sum[WIDTH-1:0] - bus.operand_b + WIDTH'(1); sc_cb = &bus.operand_a; end
      8'b00000111: begin sc_result = bus.operand_a - WIDTH'(1); sc_cb = ~|bus.operand_a; end
      default: ;
    endcase
  end

  // One shift-add multiply step: add multiplicand if multiplier LSB set, shift right.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_df;
  logic [WIDTH-1:0] div_rem_n;
  logic [WIDTH-1:0] div_quo_n;

  // One restoring-division step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    div_sh    = {hi, lo[WIDTH-1]};
    div_ge    = (div_sh >= {1'b0, opnd});
    div_df    = div_sh[WIDTH-1:0] - opnd;
    div_rem_n = div_ge ? div_df : div_sh[WIDTH-1:0];
    div_quo_n = {lo[WIDTH-2:0], div_ge};
  end
`endif

  // Control FSM, engine registers and the registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cb_q        <= 1'b0;
      ext_q       <= '0;
      zero_q      <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= S_MUL;
              cnt   <= CNT_W'(WIDTH);
              hi    <= '0;
              lo    <= bus.operand_b;
              opnd  <= bus.operand_a;
            end else if (is_div && (bus.operand_b != '0)) begin
              state <= S_DIV;
              cnt   <= CNT_W'(WIDTH);
              hi    <= '0;
              lo    <= bus.operand_a;
              opnd  <= bus.operand_b;
            end else begin
              result_q    <= sc_result;
              cb_q        <= sc_cb;
              ext_q       <= sc_ext;
              zero_q      <= (sc_result == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          hi  <= mul_hi_n;
          lo  <= mul_lo_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result_q    <= mul_lo_n;
            ext_q       <= mul_hi_n;
            cb_q        <= 1'b0;
            zero_q      <= (mul_lo_n == '0);
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          hi  <= div_rem_n;
          lo  <= div_quo_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result_q    <= div_quo_n;
            ext_q       <= div_rem_n;
            cb_q        <= 1'b0;
            zero_q      <= (div_quo_n == '0);
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed test of seq_alu at WIDTH=8.
// A negedge monitor pops expected {cb, ext, result} from exp_q on every delivery;
// the main thread checks latency, handshake, backpressure and async reset.
// Define ALU_DIV_EN for both files to exercise the divider.
module tb_seq_alu;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*W:0] exp_q[$];

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Present one op at a negedge once in_ready is seen; returns 1 time unit
  // after the accept edge with operands scrambled to prove capture.
  task automatic send(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit push, input logic [W-1:0] e_res, input logic e_cb,
                      input logic [W-1:0] e_ext);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("send_ready_timeout", bus.in_ready, 1);
    if (push) exp_q.push_back({e_cb, e_ext, e_res});
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.opcode    = 8'($urandom_range(0, 255));
    bus.operand_a = W'($urandom_range(0, 255));
    bus.operand_b = W'($urandom_range(0, 255));
  endtask

  // Called 1 time unit after the accept edge of a WIDTH-step op.
  task automatic engine_latency(input string tag);
    check({tag, "_busy0"}, bus.busy, 1);
    check({tag, "_rdy0"}, bus.in_ready, 0);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_ov%0d", tag, k), bus.out_valid, (k == W));
      check($sformatf("%s_busy%0d", tag, k), bus.busy, (k < W));
    end
  endtask

  // Scoreboard: one pop per delivery edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          logic [2*W:0] e;
          e = exp_q.pop_front();
          check("sb_result", bus.result, e[W-1:0]);
          check("sb_ext", bus.ext, e[2*W-1:W]);
          check("sb_cb", bus.cb, e[2*W]);
          check("sb_zero", bus.zero, (e[W-1:0] == '0));
        end
      end
    end
  end

  // Directed single-cycle vectors: opcode, A, B, result, cb
  logic [7:0]   t_op [13] = '{8'h10, 8'h20, 8'h70, 8'h7F, 8'h50, 8'h6A, 8'h02,
                              8'h03, 8'h04, 8'h05, 8'h07, 8'h06, 8'h08};
  logic [W-1:0] t_a  [13] = '{8'hF0, 8'h05, 8'h07, 8'h03, 8'hF0, 8'hF0, 8'h81,
                              8'h81, 8'h81, 8'h81, 8'h00, 8'h7F, 8'h5A};
  logic [W-1:0] t_b  [13] = '{8'h20, 8'h07, 8'h07, 8'h09, 8'h3C, 8'h3C, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
  logic [W-1:0] t_r  [13] = '{8'h10, 8'hFE, 8'h00, 8'h00, 8'h30, 8'hCC, 8'h40,
                              8'hC0, 8'h03, 8'hC0, 8'hFF, 8'h80, 8'h5A};
  logic         t_c  [13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // Main sequence
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = 8'h00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_ext", bus.ext, 0);
    check("rst_cb", bus.cb, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle ops, back to back, latency 1
    for (int i = 0; i < 13; i++) begin
      send(t_op[i], t_a[i], t_b[i], 1'b1, t_r[i], t_c[i], 8'h00);
      check($sformatf("tbl%0d_lat1", i), bus.out_valid, 1);
    end

    // Multiplies: exact full product, WIDTH-cycle latency
    send(8'h30, 8'hFF, 8'hFF, 1'b1, 8'h01, 1'b0, 8'hFE);
    check("mul_dbg_state", dbg_state, 1);
    engine_latency("mul_ff");
    send(8'h3C, 8'h0D, 8'h0B, 1'b1, 8'h8F, 1'b0, 8'h00);
    engine_latency("mul_0d");
    send(8'h31, 8'h80, 8'h04, 1'b1, 8'h00, 1'b0, 8'h02);
    engine_latency("mul_80");

    // Backpressure: hold INC 0xFF result for 5 cycles, then deliver + accept
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(8'h06, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_ov", i), bus.out_valid, 1);
      check($sformatf("bp%0d_result", i), bus.result, 8'h00);
      check($sformatf("bp%0d_cb", i), bus.cb, 1);
      check($sformatf("bp%0d_zero", i), bus.zero, 1);
      check($sformatf("bp%0d_in_ready", i), bus.in_ready, 0);
    end
    exp_q.push_back({1'b0, 8'h00, 8'h03});
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode    = 8'h10;
    bus.operand_a = 8'h01;
    bus.operand_b = 8'h02;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_b2b_ov", bus.out_valid, 1);
    check("bp_b2b_result", bus.result, 8'h03);

    // Async reset during MUL step 4 aborts it
    send(8'h30, 8'h0D, 8'h0B, 1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_result", bus.result, 0);
    check("arst_ext", bus.ext, 0);
    check("arst_dbg_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h01, 8'h81, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00);
    check("lsl_lat1", bus.out_valid, 1);

`ifdef ALU_DIV_EN
    send(8'h40, 8'h64, 8'h07, 1'b1, 8'h0E, 1'b0, 8'h02);
    engine_latency("div_64");
    send(8'h4F, 8'hFF, 8'h01, 1'b1, 8'hFF, 1'b0, 8'h00);
    engine_latency("div_ff");
    send(8'h40, 8'h5A, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h5A);
    check("div0_lat1", bus.out_valid, 1);
`else
    send(8'h40, 8'h64, 8'h07, 1'b1, 8'h64, 1'b0, 8'h00);
    check("op40_nop_lat1", bus.out_valid, 1);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("idle_out_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Same opcode map, generalised to WIDTH-bit operands.
- Single-cycle ops return after one cycle; MUL (and optional DIV) run as WIDTH-step iterative engines.
- Sits between the register file and the writeback stage, with valid/ready handshakes on input and output.

Parameters:
- WIDTH, 8, operand/result/EXT width in bits (>=2)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation this cycle
- operand_a  input  WIDTH  operand A
- operand_b  input  WIDTH  operand B
- opcode  input  8  operation code
- out_valid  output  1  result registers hold an undelivered result
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  result (MUL: low half; DIV: quotient)
- cb  output  1  carry/borrow/compare flag
- ext  output  WIDTH  extension (MUL: high half; DIV: remainder; else 0)
- zero  output  1  result==0, registered with result
- busy  output  1  iterative engine running

Behaviour:
- Reset (async, rst=1): state=IDLE; result=0, ext=0, cb=0, zero=0, out_valid=0, busy=0; counter and engine registers cleared. Reset mid-operation aborts it; no result is produced.
- Handshake:
  - Accept occurs on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so a full output slot drained this cycle allows back-to-back accepts.
  - Operands and opcode are captured at accept; later input changes are ignored.
  - Delivery occurs on an edge where out_valid && out_ready. out_valid clears unless a new result loads on the same edge.
  - result/cb/ext/zero hold stable while out_valid && !out_ready.
- Opcode map (casex, priority as listed, x = don't care):
  - 0001xxxx ADD: result=A+B, cb=carry out.
  - 0010xxxx SUB: result=A-B, cb=1 if A<B (borrow).
  - 0011xxxx MUL: iterative; result=P[WIDTH-1:0], ext=P[2W-1:WIDTH], cb=0.
  - 0101xxxx AND; 0110xxxx XOR.
  - 0111xxxx CMP: result=0, cb=(A<B), so zero=1.
  - 00000001 LSL; 00000010 LSR. Shifts are by one bit, zero fill, cb=0.
  - 00000011 rotate right; 00000100 rotate left. cb=0.
  - 00000101 ASR (MSB replicated).
  - 00000110 INC: cb=1 on wrap from all-ones to 0.
  - 00000111 DEC: cb=1 on wrap from 0 to all-ones.
  - default: result=A (NOP), cb=0, ext=0.
- ext=0 for every op except MUL/DIV.
- States:
  - IDLE: single-cycle op accepted → output registers load on the accept edge; out_valid=1 next cycle (latency 1), state stays IDLE.
  - IDLE: MUL accepted → MUL state, busy=1, acc=0, cnt=WIDTH.
  - MUL: each edge performs one shift-add step (LSB of multiplier), cnt--. The edge where cnt goes 1→0 loads the outputs, sets out_valid, and returns to IDLE. Latency WIDTH cycles after the accept edge. in_ready=0 throughout.
  - DIV: as MUL, but each step is a restoring-division step (only with ALU_DIV_EN).
- Arithmetic is unsigned except ASR. The full 2·WIDTH product is exact: all-ones × all-ones gives ext=all-ones-minus-1, result=1.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined:
  - 0100xxxx is DIV, restoring, WIDTH-cycle latency: result=quotient, ext=remainder, cb=0.
  - B==0: completes in 1 cycle with result=all-ones, ext=A, cb=1.
- Undefined: 0100xxxx falls to default (result=A, latency 1), and no divider logic is synthesised.

Test Plan:
- WIDTH=8, ADD 0xF0+0x20 → result 0x10, cb=1, zero=0, out_valid exactly 1 cycle after accept.
- SUB 0x05-0x07 → result 0xFE, cb=1; CMP 0x07,0x07 → result 0, cb=0, zero=1.
- MUL 0xFF×0xFF → result 0x01, ext 0xFE, out_valid 8 cycles after accept; in_ready=0 and busy=1 during. Inputs changed mid-run do not affect the result.
- Backpressure: hold out_ready=0 for 5 cycles after INC 0xFF → result 0x00, cb=1, zero=1 held stable, in_ready=0. On release, a queued ADD is accepted on the same edge as delivery.
- Assert rst during MUL step 4 → all outputs 0 immediately (async). After release a fresh LSL 0x81 → result 0x02.
- ALU_DIV_EN: DIV 0x64/0x07 → result 0x0E, ext 0x02; DIV by 0 → result 0xFF, ext=A, cb=1. Without the macro, opcode 0x40 → result=A.
